meas_spi_reader: RTL and testbench

MEAS_SPI_READER -- requirements
Module: meas_spi_reader

---
 rtl/meas_spi_reader.sv | 215 +++++++++++++++++++++
 tb/tb_meas_spi_reader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_spi_reader.sv
// SPI mode-0 reader: sends a read command, then clocks in num_words 24-bit samples.
// Each sample arrives as three bytes, lowest byte first and MSB first within each byte.
module meas_spi_reader #(
   parameter int         CLK_DIV  = 3,
   parameter logic [7:0] CMD_READ = 8'h05,
   parameter int         CS_SETUP = 4,
   parameter int         CS_HOLD  = 4
) (
   input  logic        clk_12mhz,
   input  logic        rst_sync,
   input  logic        start,
   input  logic [3:0]  num_words,
   input  logic        abort,
   output logic        spi_cs,
   output logic        spi_clk,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic [23:0] word_data,
   output logic        word_valid,
   output logic        busy,
   output logic        done,
   output logic        aborted
);

   typedef enum logic [2:0] {IDLE, SETUP, CMD, DATA, HOLD} state_t;

   localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
   localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

   state_t      state, state_n;
   logic [7:0]  timer, timer_n;
   logic [3:0]  div_cnt, div_n;
   logic [4:0]  bit_cnt, bit_n;
   logic [7:0]  cmd_sr, cmd_n;
   logic [23:0] rx_sr, rx_n;
   logic [3:0]  words_left, words_n;
   logic        ab_flag, ab_n;
   logic        wv_pend, wv_pend_n;

   logic        cs_n, sck_n, mosi_n, wvalid_n, busy_n, done_n, aborted_n;
   logic [23:0] wdata_n;

   logic        half_end, final_bit, last_edge, enter_hold, hold_ab;

   always_ff @(posedge clk_12mhz or posedge rst_sync) begin
      if (rst_sync) begin
         state      <= IDLE;
         timer      <= '0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         cmd_sr     <= '0;
         rx_sr      <= '0;
         words_left <= '0;
         ab_flag    <= 1'b0;
         wv_pend    <= 1'b0;
         spi_cs     <= 1'b1;
         spi_clk    <= 1'b0;
         spi_mosi   <= 1'b0;
         word_data  <= '0;
         word_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         div_cnt    <= div_n;
         bit_cnt    <= bit_n;
         cmd_sr     <= cmd_n;
         rx_sr      <= rx_n;
         words_left <= words_n;
         ab_flag    <= ab_n;
         wv_pend    <= wv_pend_n;
         spi_cs     <= cs_n;
         spi_clk    <= sck_n;
         spi_mosi   <= mosi_n;
         word_data  <= wdata_n;
         word_valid <= wvalid_n;
         busy       <= busy_n;
         done       <= done_n;
         aborted    <= aborted_n;
      end
   end

   always_comb begin
      state_n    = state;
      timer_n    = timer;
      div_n      = div_cnt;
      bit_n      = bit_cnt;
      cmd_n      = cmd_sr;
      rx_n       = rx_sr;
      words_n    = words_left;
      ab_n       = ab_flag;
      wv_pend_n  = 1'b0;
      cs_n       = spi_cs;
      sck_n      = spi_clk;
      mosi_n     = spi_mosi;
      wdata_n    = word_data;
      wvalid_n   = 1'b0;
      busy_n     = busy;
      done_n     = 1'b0;
      aborted_n  = 1'b0;
      enter_hold = 1'b0;
      hold_ab    = 1'b0;

      half_end  = (div_cnt == DIV_LAST);
      final_bit = (words_left == 4'd0) &&
                  (((state == CMD) && (bit_cnt == 5'd7)) ||
                   ((state == DATA) && (bit_cnt == 5'd23)));
      // an abort landing on the natural last edge is just the normal finish
      last_edge = half_end && spi_clk && final_bit;

      // the word completed on the previous SCK rise is published regardless of abort
      if (wv_pend) begin
         wdata_n  = {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16]};
         wvalid_n = 1'b1;
      end

      case (state)
         IDLE: begin
            if (start) begin
               state_n = SETUP;
               timer_n = '0;
               cs_n    = 1'b0;
               busy_n  = 1'b1;
               words_n = num_words;
               ab_n    = 1'b0;
            end
         end

         SETUP: begin
            if (abort) begin
               enter_hold = 1'b1;
               hold_ab    = 1'b1;
            end else if (timer == SETUP_LAST) begin
               state_n = CMD;
               div_n   = '0;
               bit_n   = '0;
               sck_n   = 1'b0;
               mosi_n  = CMD_READ[7];
               cmd_n   = {CMD_READ[6:0], 1'b0};
            end else begin
               timer_n = timer + 8'd1;
            end
         end

         CMD, DATA: begin
            if (abort && !last_edge) begin
               enter_hold = 1'b1;
               hold_ab    = (state == CMD) || (words_left != 4'd0);
            end else if (!half_end) begin
               div_n = div_cnt + 4'd1;
            end else begin
               div_n = '0;
               if (!spi_clk) begin
                  sck_n = 1'b1;
                  if (state == DATA) begin
                     rx_n = {rx_sr[22:0], spi_miso};
                     if (bit_cnt == 5'd23) begin
                        words_n   = words_left - 4'd1;
                        wv_pend_n = 1'b1;
                     end
                  end
               end else if (final_bit) begin
                  enter_hold = 1'b1;
               end else begin
                  sck_n = 1'b0;
                  if (state == CMD) begin
                     if (bit_cnt == 5'd7) begin
                        state_n = DATA;
                        bit_n   = '0;
                        mosi_n  = 1'b0;
                     end else begin
                        bit_n  = bit_cnt + 5'd1;
                        mosi_n = cmd_sr[7];
                        cmd_n  = {cmd_sr[6:0], 1'b0};
                     end
                  end else begin
                     bit_n  = (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
                     mosi_n = 1'b0;
                  end
               end
            end
         end

         HOLD: begin
            if (timer == HOLD_LAST) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else begin
               timer_n = timer + 8'd1;
            end
         end

         default: state_n = IDLE;
      endcase

      if (enter_hold) begin
         state_n = HOLD;
         timer_n = '0;
         cs_n    = 1'b1;
         sck_n   = 1'b0;
         mosi_n  = 1'b0;
         ab_n    = hold_ab;
      end

      // registered so done/aborted coincide with the final HOLD cycle
      if ((state_n == HOLD) && (timer_n == HOLD_LAST)) begin
         done_n    = 1'b1;
         aborted_n = ab_n;
      end
   end

endmodule

// File: tb/tb_meas_spi_reader.sv
// Bench for meas_spi_reader: timeline model of each transaction plus a mode-0 SPI slave.
`timescale 1ns/1ps
module tb_meas_spi_reader;

   localparam int         D   = 3;
   localparam int         SU  = 4;
   localparam int         HO  = 4;
   localparam logic [7:0] CMD = 8'h05;

   logic        clk = 1'b0;
   logic        rst, start, abort, miso;
   logic [3:0]  num_words;
   logic        spi_cs, spi_clk, spi_mosi, word_valid, busy, done, aborted;
   logic [23:0] word_data;

   logic        f_start, f_abort, f_miso;
   logic        f_cs, f_sck, f_mosi, f_wv, f_busy, f_done, f_ab;
   logic [23:0] f_wd;

   always #5 clk = ~clk;

   meas_spi_reader #(.CLK_DIV(D), .CMD_READ(CMD), .CS_SETUP(SU), .CS_HOLD(HO)) u_dut (
      .clk_12mhz(clk), .rst_sync(rst), .start(start), .num_words(num_words), .abort(abort),
      .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(miso),
      .word_data(word_data), .word_valid(word_valid), .busy(busy), .done(done), .aborted(aborted));

   meas_spi_reader #(.CLK_DIV(2)) u_fast (
      .clk_12mhz(clk), .rst_sync(rst), .start(f_start), .num_words(4'd1), .abort(f_abort),
      .spi_cs(f_cs), .spi_clk(f_sck), .spi_mosi(f_mosi), .spi_miso(f_miso),
      .word_data(f_wd), .word_valid(f_wv), .busy(f_busy), .done(f_done), .aborted(f_ab));

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   always @(posedge clk) edge_n++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         if (errors <= 40) $display("FAIL %s actual=%0h required=%0h at edge %0d", nm, act, req, edge_n);
      end
   endtask

   // ---------------- slave ----------------
   logic [7:0] sbytes [0:44];
   logic [7:0] dummy;
   int         nfall;

   function automatic logic miso_of(input int k);
      logic [7:0] b;
      int i;
      if (k < 8) begin
         b = dummy;
         return b[7 - k];
      end
      i = (k - 8) / 8;
      if (i >= 45) return 1'b0;
      b = sbytes[i];
      return b[7 - ((k - 8) % 8)];
   endfunction

   always @(negedge spi_cs) begin
      nfall = 0;
      miso  = miso_of(0);
   end
   always @(negedge spi_clk) begin
      nfall = nfall + 1;
      miso  = miso_of(nfall);
   end

   // ---------------- model ----------------
   bit          m_active = 1'b0;
   int          m_e0, m_n, m_l;
   bit          m_ab;
   logic [23:0] m_words [0:14];
   logic [23:0] last_word = '0;

   function automatic int lfull(input int n);
      return SU + 2 * D * (8 + 24 * n);
   endfunction

   function automatic int rise_of(input int w);
      return SU + 2 * D * (8 + 24 * w + 23) + D;
   endfunction

   always @(negedge clk) begin
      int j, b, ph;
      logic [7:0] cmd_v;
      logic e_cs, e_sck, e_busy, e_done, e_ab, e_wv, e_mosi, c_mosi;
      cmd_v = CMD;
      e_cs = 1'b1; e_sck = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_ab = 1'b0;
      e_wv = 1'b0; e_mosi = 1'b0; c_mosi = 1'b0;
      if (m_active) begin
         j = edge_n - m_e0;
         if (j >= 0 && j < m_l) e_cs = 1'b0;
         if (j >= SU && j < m_l) begin
            b      = (j - SU) / (2 * D);
            ph     = (j - SU) % (2 * D);
            e_sck  = (ph >= D);
            c_mosi = 1'b1;
            e_mosi = (b < 8) ? cmd_v[7 - b] : 1'b0;
         end
         e_busy = (j >= 0) && (j < m_l + HO);
         e_done = (j == m_l + HO - 1);
         e_ab   = e_done && m_ab;
         for (int w = 0; w < m_n; w++) begin
            if (rise_of(w) < m_l && j == rise_of(w) + 1) begin
               e_wv      = 1'b1;
               last_word = m_words[w];
            end
         end
      end
      chk("spi_cs", 32'(spi_cs), 32'(e_cs));
      chk("spi_clk", 32'(spi_clk), 32'(e_sck));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("aborted", 32'(aborted), 32'(e_ab));
      chk("word_valid", 32'(word_valid), 32'(e_wv));
      chk("word_data", 32'(word_data), 32'(last_word));
      if (c_mosi) chk("spi_mosi", 32'(spi_mosi), 32'(e_mosi));
   end

   // ---------------- monitors for literal checks ----------------
   int          mon_cs_low, mon_busy, mon_rise, mon_wv, mon_done, mon_ab;
   logic [31:0] mon_mosi;
   int          mon_wv_t [0:15];
   logic [23:0] mon_wv_d [0:15];
   logic        sck_prev = 1'b0;

   task automatic mon_clear();
      mon_cs_low = 0; mon_busy = 0; mon_rise = 0; mon_wv = 0; mon_done = 0; mon_ab = 0;
      mon_mosi = '0;
   endtask

   always @(negedge clk) begin
      if (!spi_cs) mon_cs_low++;
      if (busy) mon_busy++;
      if (spi_clk && !sck_prev) begin
         mon_rise++;
         mon_mosi = {mon_mosi[30:0], spi_mosi};
      end
      sck_prev = spi_clk;
      if (word_valid) begin
         if (mon_wv < 16) begin
            mon_wv_t[mon_wv] = edge_n;
            mon_wv_d[mon_wv] = word_data;
         end
         mon_wv++;
      end
      if (done) mon_done++;
      if (aborted) mon_ab++;
   end

   int   f_busy_n = 0, f_wv_n = 0, f_done_n = 0, f_rise_n = 0;
   int   f_rise_e [0:1];
   logic f_sck_prev = 1'b0;

   always @(negedge clk) begin
      if (f_busy) f_busy_n++;
      if (f_wv) f_wv_n++;
      if (f_done) f_done_n++;
      if (f_sck && !f_sck_prev) begin
         if (f_rise_n < 2) f_rise_e[f_rise_n] = edge_n;
         f_rise_n++;
      end
      f_sck_prev = f_sck;
   end

   // ---------------- stimulus ----------------
   task automatic run_txn(input int n, input int ja, input bit stray);
      int lf, tot, js;
      bit taken;
      lf = lfull(n);
      for (int w = 0; w < n; w++) m_words[w] = {sbytes[3*w+2], sbytes[3*w+1], sbytes[3*w]};
      @(posedge clk); #1;
      taken    = (ja >= 1) && (ja < lf);
      m_n      = n;
      m_l      = taken ? ja : lf;
      m_ab     = taken && ((n == 0) || (rise_of(n - 1) >= ja));
      m_e0     = edge_n + 1;
      m_active = 1'b1;
      js = stray ? int'($urandom_range(1, m_l + HO)) : 0;
      num_words = 4'(n);
      start     = 1'b1;
      tot = m_l + HO + 3;
      for (int j = 1; j <= tot; j++) begin
         @(posedge clk); #1;
         start     = (j == js);
         abort     = (j == ja);
         num_words = 4'($urandom_range(0, 15));
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic rand_bytes();
      for (int i = 0; i < 45; i++) sbytes[i] = 8'($urandom_range(0, 255));
      dummy = 8'($urandom_range(0, 255));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int n, ja;
      rst = 1'b1; start = 1'b0; abort = 1'b0; num_words = '0; miso = 1'b0;
      f_start = 1'b0; f_abort = 1'b0; f_miso = 1'b1;
      dummy = 8'hC3;
      for (int i = 0; i < 45; i++) sbytes[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs", 32'(spi_cs), 32'd1);
      chk("rst_sck", 32'(spi_clk), 32'd0);
      chk("rst_data", 32'(word_data), 32'd0);
      rst = 1'b0;

      // one word, bytes 12 34 56
      sbytes[0] = 8'h12; sbytes[1] = 8'h34; sbytes[2] = 8'h56;
      mon_clear();
      run_txn(1, 0, 1'b0);
      chk("w1_data", 32'(word_data), 32'h563412);
      chk("w1_cs_low", 32'(mon_cs_low), 32'd196);
      chk("w1_mosi", mon_mosi, 32'h05000000);
      chk("w1_valid_cnt", 32'(mon_wv), 32'd1);
      chk("w1_done_cnt", 32'(mon_done), 32'd1);

      // zero words: command only
      mon_clear();
      run_txn(0, 0, 1'b0);
      chk("w0_rises", 32'(mon_rise), 32'd8);
      chk("w0_valid_cnt", 32'(mon_wv), 32'd0);
      chk("w0_busy", 32'(mon_busy), 32'd56);
      chk("w0_done_cnt", 32'(mon_done), 32'd1);

      // three words back to back
      sbytes[0] = 8'hA5; sbytes[1] = 8'hA5; sbytes[2] = 8'hA5;
      sbytes[3] = 8'h01; sbytes[4] = 8'h00; sbytes[5] = 8'h00;
      sbytes[6] = 8'hFF; sbytes[7] = 8'hFF; sbytes[8] = 8'hFF;
      mon_clear();
      run_txn(3, 0, 1'b0);
      chk("w3_valid_cnt", 32'(mon_wv), 32'd3);
      chk("w3_gap01", 32'(mon_wv_t[1] - mon_wv_t[0]), 32'd144);
      chk("w3_gap12", 32'(mon_wv_t[2] - mon_wv_t[1]), 32'd144);
      chk("w3_d0", 32'(mon_wv_d[0]), 32'hA5A5A5);
      chk("w3_d1", 32'(mon_wv_d[1]), 32'h000001);
      chk("w3_d2", 32'(mon_wv_d[2]), 32'hFFFFFF);

      // abort during 10th data bit of word 2 of 4
      rand_bytes();
      mon_clear();
      run_txn(4, SU + 2 * D * 41 + 2, 1'b0);
      chk("ab_valid_cnt", 32'(mon_wv), 32'd1);
      chk("ab_cs_low", 32'(mon_cs_low), 32'd252);
      chk("ab_done_cnt", 32'(mon_done), 32'd1);
      chk("ab_aborted_cnt", 32'(mon_ab), 32'd1);

      // abort while the final word_valid is high: word kept, not flagged aborted
      rand_bytes();
      mon_clear();
      run_txn(1, rise_of(0) + 2, 1'b0);
      chk("late_ab_valid", 32'(mon_wv), 32'd1);
      chk("late_ab_aborted", 32'(mon_ab), 32'd0);
      chk("late_ab_done", 32'(mon_done), 32'd1);

      // reset during the command phase while SCK is high
      rand_bytes();
      @(posedge clk); #1;
      m_n = 2; m_l = lfull(2); m_ab = 1'b0; m_e0 = edge_n + 1; m_active = 1'b1;
      num_words = 4'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (edge_n < m_e0 + SU + 3 * D) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_sck", 32'(spi_clk), 32'd1);
      #1;
      rst = 1'b1;
      m_active = 1'b0;
      last_word = '0;
      #1;
      chk("async_rst_cs", 32'(spi_cs), 32'd1);
      chk("async_rst_sck", 32'(spi_clk), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      mon_clear();
      repeat (60) @(posedge clk);
      #1;
      chk("rst_no_done", 32'(mon_done), 32'd0);
      rand_bytes();
      mon_clear();
      run_txn(1, 0, 1'b0);
      chk("post_rst_done", 32'(mon_done), 32'd1);
      chk("post_rst_valid", 32'(mon_wv), 32'd1);

      // CLK_DIV=2 instance with a second start while busy
      @(posedge clk); #1;
      f_start = 1'b1;
      @(posedge clk); #1;
      f_start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      f_start = 1'b1;
      @(posedge clk); #1;
      f_start = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      chk("fast_period", 32'(f_rise_e[1] - f_rise_e[0]), 32'd4);
      chk("fast_rises", 32'(f_rise_n), 32'd32);
      chk("fast_busy", 32'(f_busy_n), 32'd136);
      chk("fast_done_cnt", 32'(f_done_n), 32'd1);
      chk("fast_valid_cnt", 32'(f_wv_n), 32'd1);
      chk("fast_data", 32'(f_wd), 32'hFFFFFF);

      // randomized transactions, including maximum word count
      for (int t = 0; t < 25; t++) begin
         rand_bytes();
         n  = (t == 0) ? 15 : int'($urandom_range(0, 4));
         ja = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lfull(n) + HO + 2)) : 0;
         run_txn(n, ja, ($urandom_range(0, 1) == 1));
      end

      repeat (5) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
